// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: a start strobe opens a frame, WIDTH bits are shifted in MSB-first.
// Define SIPO_PARITY_EN to add a trailing even-parity bit per frame.
module sipo_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] pdata,
  output logic             pvalid,
  output logic             busy,
  output logic             abort,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             parity_err,
  output logic [1:0]       dbg_state
);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pvalid_q, pvalid_d;
  logic             abort_q, abort_d;
  logic [WIDTH-1:0] word_nxt;
`ifdef SIPO_PARITY_EN
  logic             perr_q, perr_d;
`endif

  assign word_nxt = {shreg_q[WIDTH-2:0], sin};

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    pdata_d  = pdata_q;
    cnt_d    = cnt_q;
    pvalid_d = 1'b0;
    abort_d  = 1'b0;
`ifdef SIPO_PARITY_EN
    perr_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // sin_en is ignored here, including in the start cycle
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          abort_d = 1'b1;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (sin_en) begin
          shreg_d = word_nxt;
          if (cnt_q == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
            state_d = PAR;
            cnt_d   = CNT_W'(WIDTH);
`else
            state_d  = IDLE;
            cnt_d    = '0;
            pdata_d  = word_nxt;
            pvalid_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef SIPO_PARITY_EN
      PAR: begin
        if (start) begin
          state_d = SHIFT;
          abort_d = 1'b1;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (sin_en) begin
          state_d  = IDLE;
          cnt_d    = '0;
          pdata_d  = shreg_q;
          pvalid_d = 1'b1;
          perr_d   = (^shreg_q) ^ sin;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      pdata_q  <= '0;
      cnt_q    <= '0;
      pvalid_q <= 1'b0;
      abort_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      pdata_q  <= pdata_d;
      cnt_q    <= cnt_d;
      pvalid_q <= pvalid_d;
      abort_q  <= abort_d;
`ifdef SIPO_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  assign pdata     = pdata_q;
  assign pvalid    = pvalid_q;
  assign abort     = abort_q;
  assign bit_cnt   = cnt_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
`ifdef SIPO_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed frames plus randomized frames, gaps and restarts,
// checked against a bit-accumulating frame model and a completion scoreboard.
module tb_sipo_deserializer;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef SIPO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic          start = 1'b0;
  logic          sin = 1'b0;
  logic          sin_en = 1'b0;
  logic [W-1:0]  pdata;
  logic          pvalid, busy, abort, parity_err;
  logic [CW-1:0] bit_cnt;
  logic [1:0]    dbg_state;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .clrn(clrn), .start(start), .sin(sin), .sin_en(sin_en),
    .pdata(pdata), .pvalid(pvalid), .busy(busy), .abort(abort),
    .bit_cnt(bit_cnt), .parity_err(parity_err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard queues, one entry per completed frame
  logic [W-1:0] exp_q[$];
  logic         exp_perr_q[$];
  int           exp_cyc_q[$];

  // frame-level model state
  bit           m_busy  = 1'b0;
  bit           m_par   = 1'b0;
  int           m_nbits = 0;
  bit           m_abort = 1'b0;
  logic [W-1:0] m_word  = '0;

  // driver: one cycle of inputs, checking the previous cycle's visible status first
  task automatic drive(input bit st, input bit en, input bit s);
    @(negedge clk);
    if (clrn) begin
      check("bit_cnt", 64'(bit_cnt), 64'(m_nbits));
      check("busy", 64'(busy), 64'(m_busy));
      check("abort", 64'(abort), 64'(m_abort));
    end
    start = st; sin_en = en; sin = s;
    m_abort = 1'b0;
    if (st) begin
      m_abort = m_busy;
      m_busy  = 1'b1;
      m_par   = 1'b0;
      m_nbits = 0;
      m_word  = '0;
    end else if (en && m_busy) begin
      if (!m_par) begin
        m_word  = (m_word << 1) | W'(s);
        m_nbits = m_nbits + 1;
        if (m_nbits == W) begin
          if (PAR_EN) m_par = 1'b1;
          else begin
            exp_q.push_back(m_word);
            exp_perr_q.push_back(1'b0);
            exp_cyc_q.push_back(cyc_n + 1);
            m_busy  = 1'b0;
            m_nbits = 0;
          end
        end
      end else begin
        exp_q.push_back(m_word);
        exp_perr_q.push_back((^m_word) ^ s);
        exp_cyc_q.push_back(cyc_n + 1);
        m_busy  = 1'b0;
        m_par   = 1'b0;
        m_nbits = 0;
      end
    end
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit p, input int gmax,
                            input int gap_pos, input int gap_len, input bit st_en);
    drive(1'b1, st_en, 1'b1);
    for (int i = 0; i < W; i++) begin
      if (i == gap_pos) repeat (gap_len) drive(1'b0, 1'b0, 1'($urandom));
      repeat ($urandom_range(0, gmax)) drive(1'b0, 1'b0, 1'($urandom));
      drive(1'b0, 1'b1, w[W-1-i]);
    end
    if (PAR_EN) begin
      repeat ($urandom_range(0, gmax)) drive(1'b0, 1'b0, 1'($urandom));
      drive(1'b0, 1'b1, p);
    end
  endtask

  task automatic send_partial(input int n);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'($urandom));
  endtask

  task automatic check_reset_outputs();
    check("rst_pdata", 64'(pdata), 64'd0);
    check("rst_pvalid", 64'(pvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    check("rst_bit_cnt", 64'(bit_cnt), 64'd0);
    check("rst_parity_err", 64'(parity_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 clrn = 1'b0;
    #1 check_reset_outputs();
    start = 1'b0; sin_en = 1'b0; sin = 1'b0;
    m_busy = 1'b0; m_par = 1'b0; m_nbits = 0; m_abort = 1'b0; m_word = '0;
    @(negedge clk);
    @(posedge clk);
    #2 clrn = 1'b1;
  endtask

  // monitor: pops and compares whenever pvalid is presented
  logic [W-1:0] last_word = '0;
  always @(negedge clk) begin
    if (!clrn) begin
      exp_q.delete(); exp_perr_q.delete(); exp_cyc_q.delete();
      last_word = '0;
      check("pvalid_in_reset", 64'(pvalid), 64'd0);
    end else if (pvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pvalid", 64'(pvalid), 64'd0);
      end else begin
        logic [W-1:0] ew;
        logic         ep;
        int           ec;
        ew = exp_q.pop_front();
        ep = exp_perr_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("pdata", 64'(pdata), 64'(ew));
        check("parity_err", 64'(parity_err), 64'(ep));
        check("pvalid_cycle", 64'(cyc_n), 64'(ec));
        last_word = ew;
      end
    end else begin
      check("pdata_hold", 64'(pdata), 64'(last_word));
      check("parity_err_idle", 64'(parity_err), 64'd0);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    #1 clrn = 1'b1;

    send_frame(8'hB2, 1'b0, 0, -1, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    send_frame(8'hB2, 1'b1, 0, 4, 3, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    send_partial(5);
    send_frame(8'h3C, 1'b0, 0, -1, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 0, -1, 0, 1'b0);
    send_partial(4);
    async_reset();
    send_frame(8'h5A, 1'b1, 0, -1, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, 0, -1, 0, 1'b1);
    send_frame(8'h80, 1'b1, 0, -1, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 2) send_partial($urandom_range(0, W - 1));
      send_frame(W'($urandom), 1'($urandom), $urandom_range(0, 2), -1, 0, 1'($urandom));
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom), 1'($urandom));
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
